// File: rtl/clint_irq_ctrl.sv
// clint_irq_ctrl: core-local interrupt/exception sequencer.
// Detects ecall/ebreak/mret and enabled external interrupts. It then writes
// mepc, mcause and mstatus through the CSR file's clint port and redirects
// the PC to mtvec (trap) or to mepc (return). The pipeline is held while the
// sequence runs.
// Build option: define CLINT_EBREAK_EN to make ebreak trap with cause 3.
// When it is undefined, ebreak is not decoded and executes as a no-op.
module clint_irq_ctrl #(
  parameter int unsigned INT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             div_started_i,
  input  logic             global_int_en_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      data_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_0004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_W_MRET,
    S_ASSERT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        we_q, we_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] data_q, data_d;
  logic        int_assert_q, int_assert_d;
  logic [31:0] int_addr_q, int_addr_d;

  logic        ev_sync, ev_mret, ev_async;
  logic [31:0] sync_cause;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[7] = m[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r    = m;
    r[3] = m[7];
    r[7] = 1'b1;
    return r;
  endfunction

  // Event decode of the instruction in execute and the interrupt lines.
  always_comb begin
    ev_sync    = 1'b0;
    sync_cause = CAUSE_ECALL;
    if (inst_i == INST_ECALL) begin
      ev_sync = 1'b1;
    end
`ifdef CLINT_EBREAK_EN
    else if (inst_i == INST_EBREAK) begin
      ev_sync    = 1'b1;
      sync_cause = CAUSE_EBREAK;
    end
`endif
    ev_mret  = (inst_i == INST_MRET);
    ev_async = (|int_flag_i) && global_int_en_i && !div_started_i;
  end

  // Hold covers the detect cycle and every CSR write state.
  assign hold_flag_o = ((state_q == S_IDLE) && (ev_sync || ev_mret || ev_async)) ||
                       ((state_q != S_IDLE) && (state_q != S_ASSERT));

  // Next state and capture; the registered outputs are staged from state_d
  // so that each write is visible during its own state's cycle.
  always_comb begin
    state_d      = state_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    we_d         = 1'b0;
    waddr_d      = '0;
    data_d       = '0;
    int_assert_d = 1'b0;
    int_addr_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (ev_sync) begin
          state_d = S_W_MEPC;
          epc_d   = inst_addr_i;
          cause_d = sync_cause;
        end else if (ev_mret) begin
          state_d = S_W_MRET;
        end else if (ev_async) begin
          state_d = S_W_MEPC;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = CAUSE_EXT;
        end
      end
      S_W_MEPC:    state_d = S_W_MCAUSE;
      S_W_MCAUSE:  state_d = S_W_MSTATUS;
      S_W_MSTATUS: state_d = S_ASSERT;
      S_W_MRET:    state_d = S_ASSERT;
      S_ASSERT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    case (state_d)
      S_W_MEPC: begin
        we_d    = 1'b1;
        waddr_d = CSR_MEPC;
        data_d  = epc_d;
      end
      S_W_MCAUSE: begin
        we_d    = 1'b1;
        waddr_d = CSR_MCAUSE;
        data_d  = cause_q;
      end
      S_W_MSTATUS: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = trap_mstatus(csr_mstatus_i);
      end
      S_W_MRET: begin
        we_d    = 1'b1;
        waddr_d = CSR_MSTATUS;
        data_d  = mret_mstatus(csr_mstatus_i);
      end
      S_ASSERT: begin
        int_assert_d = 1'b1;
        int_addr_d   = (state_q == S_W_MRET) ? csr_mepc_i : csr_mtvec_i;
      end
      default: ;
    endcase
  end

  // State, captured trap info and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      epc_q        <= '0;
      cause_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      data_q       <= data_d;
      int_assert_q <= int_assert_d;
      int_addr_q   <= int_addr_d;
    end
  end

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign data_o       = data_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Scoreboard bench for clint_irq_ctrl: directed events push the expected CSR
// writes / redirect (with their cycle) into a queue; a negedge monitor pops
// and compares whenever the DUT writes or asserts.
module tb_clint_irq_ctrl;

  localparam int unsigned INT_W = 8;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic [INT_W-1:0] int_flag;
  logic [31:0]      inst, inst_addr, jump_addr;
  logic             jump_flag, div_started, gie;
  logic [31:0]      mtvec, mepc, mstatus;
  logic             we_o, hold_flag_o, int_assert_o;
  logic [31:0]      waddr_o, data_o, int_addr_o;

  clint_irq_ctrl #(.INT_W(INT_W)) dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag), .inst_i(inst),
    .inst_addr_i(inst_addr), .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
    .div_started_i(div_started), .global_int_en_i(gie), .csr_mtvec_i(mtvec),
    .csr_mepc_i(mepc), .csr_mstatus_i(mstatus), .we_o(we_o), .waddr_o(waddr_o),
    .data_o(data_o), .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o),
    .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_assert;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void push_w(int c, logic [31:0] a, logic [31:0] d);
    exp_t e;
    e.is_assert = 1'b0; e.addr = a; e.data = d; e.cyc = c;
    sb.push_back(e);
  endfunction

  function automatic void push_a(int c, logic [31:0] target);
    exp_t e;
    e.is_assert = 1'b1; e.addr = '0; e.data = target; e.cyc = c;
    sb.push_back(e);
  endfunction

  function automatic void push_trap(int n, logic [31:0] epc, logic [31:0] cause,
                                    logic [31:0] mst, logic [31:0] vec);
    push_w(n + 1, 32'h341, epc);
    push_w(n + 2, 32'h342, cause);
    push_w(n + 3, 32'h300, mst);
    push_a(n + 4, vec);
  endfunction

  // Monitor: every write or redirect must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a_addr, a_data;
    bit          ok;
    if (we_o || int_assert_o) begin
      n_cmp++;
      a_addr = int_assert_o ? 32'h0 : waddr_o;
      a_data = int_assert_o ? int_addr_o : data_o;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got we=%b assert=%b addr=%h data=%h cyc=%0d, required no activity",
                 we_o, int_assert_o, a_addr, a_data, cyc);
      end else begin
        e  = sb.pop_front();
        ok = (we_o != int_assert_o) && (int_assert_o == e.is_assert) &&
             (a_addr == e.addr) && (a_data == e.data) && (cyc == e.cyc);
        if (!ok) begin
          n_err++;
          $display("FAIL sb_out: got we=%b assert=%b addr=%h data=%h cyc=%0d, required assert=%b addr=%h data=%h cyc=%0d",
                   we_o, int_assert_o, a_addr, a_data, cyc, e.is_assert, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst = NOP; int_flag = '0; jump_flag = 1'b0; div_started = 1'b0;
  endtask

  // Checks hold over n cycles starting at the detect cycle; clears the
  // event inputs after the detect cycle.
  task automatic hold_seq(input string nm, input int n, input logic [7:0] pat);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        tick();
        if (k == 1) idle_inputs();
      end
      #1;
      chk(nm, {31'b0, hold_flag_o}, {31'b0, pat[k]});
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk(nm, sb.size(), 0);
  endtask

  int n;

  initial begin
    rst = 1'b1; idle_inputs();
    inst_addr = '0; jump_addr = '0; gie = 1'b1;
    mtvec = 32'h400; mepc = '0; mstatus = 32'h8;
    tick(); tick();
    chk("rst_we", {31'b0, we_o}, 0);
    chk("rst_waddr", waddr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_assert", {31'b0, int_assert_o}, 0);
    chk("rst_int_addr", int_addr_o, 0);
    chk("rst_hold", {31'b0, hold_flag_o}, 0);
    rst = 1'b0;
    tick();

    // ecall
    inst = ECALL; inst_addr = 32'h100; n = cyc;
    push_trap(n, 32'h100, 32'd11, 32'h80, 32'h400);
    hold_seq("hold_ecall", 6, 8'h0F);
    drain("drain_ecall");

    // external interrupt while execute redirects
    tick();
    int_flag = 8'h01; jump_flag = 1'b1; jump_addr = 32'h200; inst_addr = 32'h300; n = cyc;
    push_trap(n, 32'h200, 32'h8000_0004, 32'h80, 32'h400);
    hold_seq("hold_async", 6, 8'h0F);
    drain("drain_async");

    // interrupt masked by MIE=0
    tick();
    gie = 1'b0; int_flag = 8'h01;
    for (int k = 0; k < 4; k++) begin
      #1; chk("hold_masked", {31'b0, hold_flag_o}, 0);
      tick();
    end
    idle_inputs(); gie = 1'b1;

    // mret
    mstatus = 32'h80; mepc = 32'h204; inst = MRET; n = cyc;
    push_w(n + 1, 32'h300, 32'h88);
    push_a(n + 2, 32'h204);
    hold_seq("hold_mret", 4, 8'h03);
    drain("drain_mret");
    mstatus = 32'h8;

    // interrupt deferred while a divide is in flight
    tick();
    int_flag = 8'h10; div_started = 1'b1; inst_addr = 32'h500;
    for (int k = 0; k < 5; k++) begin
      #1; chk("hold_div", {31'b0, hold_flag_o}, 0);
      tick();
    end
    div_started = 1'b0; n = cyc;
    push_trap(n, 32'h500, 32'h8000_0004, 32'h80, 32'h400);
    hold_seq("hold_div_go", 6, 8'h0F);
    drain("drain_div");

    // ecall and interrupt together: ecall wins
    tick();
    inst = ECALL; inst_addr = 32'h140; int_flag = 8'h01; n = cyc;
    push_trap(n, 32'h140, 32'd11, 32'h80, 32'h400);
    hold_seq("hold_prio", 6, 8'h0F);
    drain("drain_prio");

    // reset during W_MCAUSE
    tick();
    inst = ECALL; inst_addr = 32'h180; n = cyc;
    push_w(n + 1, 32'h341, 32'h180);
    push_w(n + 2, 32'h342, 32'd11);
    #1; chk("hold_rst_evt", {31'b0, hold_flag_o}, 1);
    tick(); idle_inputs();
    tick(); rst = 1'b1;
    #1; chk("hold_rst_mcause", {31'b0, hold_flag_o}, 1);
    tick(); rst = 1'b0;
    #1;
    chk("rst_mid_we", {31'b0, we_o}, 0);
    chk("rst_mid_waddr", waddr_o, 0);
    chk("rst_mid_data", data_o, 0);
    chk("rst_mid_assert", {31'b0, int_assert_o}, 0);
    chk("rst_mid_int_addr", int_addr_o, 0);
    chk("rst_mid_hold", {31'b0, hold_flag_o}, 0);
    tick(); tick(); tick();
    drain("drain_rst");

    // ebreak
    tick();
    inst = EBREAK; inst_addr = 32'h1C0;
`ifdef CLINT_EBREAK_EN
    n = cyc;
    push_trap(n, 32'h1C0, 32'd3, 32'h80, 32'h400);
    hold_seq("hold_ebreak", 6, 8'h0F);
`else
    hold_seq("hold_ebreak", 4, 8'h00);
`endif
    drain("drain_ebreak");

    // back-to-back: mret present during ASSERT is ignored, accepted next cycle
    tick();
    inst = ECALL; inst_addr = 32'h240; mepc = 32'h300; n = cyc;
    push_trap(n, 32'h240, 32'd11, 32'h80, 32'h400);
    push_w(n + 6, 32'h300, 32'h80);
    push_a(n + 7, 32'h300);
    #1; chk("hold_b2b_evt", {31'b0, hold_flag_o}, 1);
    tick(); inst = NOP;
    tick(); tick(); tick();
    inst = MRET;
    #1; chk("hold_b2b_assert", {31'b0, hold_flag_o}, 0);
    tick();
    #1; chk("hold_b2b_mret", {31'b0, hold_flag_o}, 1);
    tick(); inst = NOP;
    #1; chk("hold_b2b_wmret", {31'b0, hold_flag_o}, 1);
    tick();
    #1; chk("hold_b2b_end", {31'b0, hold_flag_o}, 0);
    drain("drain_b2b");

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
